// File: rtl/bcd2bin_seq.sv
`default_nettype none
// bcd2bin_seq: sequential reverse double-dabble BCD-to-binary converter, one bit per clock.
// Optional macro BCD2BIN_DIGIT_CHECK_EN: nibbles > 9 raise Err and force Bin to 0.
module bcd2bin_seq #(
   parameter int DIGITS = 4,
   parameter int BIN_W  = 14
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  Start,
   input  logic [DIGITS*4-1:0]   BCD,
   output logic [BIN_W-1:0]      Bin,
   output logic                  Busy,
   output logic                  Done,
   output logic                  Err
);

   localparam int SR_W  = DIGITS*4 + BIN_W;
   localparam int CNT_W = $clog2(BIN_W + 1);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(BIN_W - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t             state;
   logic [SR_W-1:0]    sr;
   logic [SR_W-1:0]    sr_next;
   logic [CNT_W-1:0]   count;
   logic [BIN_W-1:0]   bin_result;

   // One iteration: shift right, then pull every digit that reached >= 8 back by 3.
   always_comb begin
      sr_next = sr >> 1;
      for (int d = 0; d < DIGITS; d++) begin
         if (sr_next[BIN_W + 4*d + 3]) begin
            sr_next[BIN_W + 4*d +: 4] = sr_next[BIN_W + 4*d +: 4] - 4'd3;
         end
      end
   end

`ifdef BCD2BIN_DIGIT_CHECK_EN
   logic bad;
   logic bad_in;
   logic err_r;

   always_comb begin
      bad_in = 1'b0;
      for (int d = 0; d < DIGITS; d++) begin
         if (BCD[4*d +: 4] > 4'd9) begin
            bad_in = 1'b1;
         end
      end
   end

   assign bin_result = bad ? '0 : sr_next[BIN_W-1:0];
   assign Err        = err_r;
`else
   assign bin_result = sr_next[BIN_W-1:0];
   assign Err        = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         sr    <= '0;
         count <= '0;
         Bin   <= '0;
         Busy  <= 1'b0;
         Done  <= 1'b0;
`ifdef BCD2BIN_DIGIT_CHECK_EN
         bad   <= 1'b0;
         err_r <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (Start) begin
                  sr    <= {BCD, BIN_W'(0)};
                  count <= '0;
                  Busy  <= 1'b1;
                  state <= SHIFT;
`ifdef BCD2BIN_DIGIT_CHECK_EN
                  bad   <= bad_in;
                  err_r <= 1'b0;
`endif
               end
            end
            SHIFT: begin
               sr    <= sr_next;
               count <= count + CNT_W'(1);
               if (count == LAST) begin
                  Bin   <= bin_result;
                  Done  <= 1'b1;
                  state <= DONE;
`ifdef BCD2BIN_DIGIT_CHECK_EN
                  err_r <= bad;
`endif
               end
            end
            DONE: begin
               Done  <= 1'b0;
               Busy  <= 1'b0;
               state <= IDLE;
`ifdef BCD2BIN_DIGIT_CHECK_EN
               err_r <= 1'b0;
`endif
            end
            default: begin
               state <= IDLE;
               Busy  <= 1'b0;
               Done  <= 1'b0;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_bcd2bin_seq.sv
`default_nettype none
// tb_bcd2bin_seq: randomized and directed checks of bcd2bin_seq against a decimal-value model.
`timescale 1ns/1ps
module tb_bcd2bin_seq;

   localparam int DIGITS = 4;
   localparam int BIN_W  = 14;

   logic                 clk   = 1'b0;
   logic                 rst_n = 1'b0;
   logic                 Start = 1'b0;
   logic [DIGITS*4-1:0]  BCD   = '0;
   logic [BIN_W-1:0]     Bin;
   logic                 Busy;
   logic                 Done;
   logic                 Err;

   int      n_cmp = 0;
   int      n_bad = 0;
   longint  edge_cnt = 0;

   bcd2bin_seq #(.DIGITS(DIGITS), .BIN_W(BIN_W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .Start (Start),
      .BCD   (BCD),
      .Bin   (Bin),
      .Busy  (Busy),
      .Done  (Done),
      .Err   (Err)
   );

   always #5 clk = ~clk;
   always @(posedge clk) edge_cnt <= edge_cnt + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic int bcd_value(input logic [DIGITS*4-1:0] b);
      int v = 0;
      for (int d = DIGITS-1; d >= 0; d--) v = v*10 + int'(b[4*d +: 4]);
      return v;
   endfunction

   function automatic logic [DIGITS*4-1:0] to_bcd(input int n);
      logic [DIGITS*4-1:0] b;
      int m = n;
      for (int d = 0; d < DIGITS; d++) begin
         b[4*d +: 4] = 4'(m % 10);
         m = m / 10;
      end
      return b;
   endfunction

   function automatic logic has_bad(input logic [DIGITS*4-1:0] b);
      logic r = 1'b0;
      for (int d = 0; d < DIGITS; d++) if (b[4*d +: 4] > 4'd9) r = 1'b1;
      return r;
   endfunction

   // Reference model: an accepted value appears on Bin BIN_W edges later, Done for one cycle,
   // busy from the accepting edge until the edge after Done.
   int               ph;
   logic [BIN_W-1:0] m_bin, p_bin;
   logic             m_busy, m_done, m_err, m_known, p_bad;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ph <= 0; m_bin <= '0; m_busy <= 1'b0; m_done <= 1'b0; m_err <= 1'b0; m_known <= 1'b1;
      end else if (ph == 0) begin
         if (Start) begin
            ph     <= 1;
            m_busy <= 1'b1;
            p_bin  <= BIN_W'(bcd_value(BCD));
            p_bad  <= has_bad(BCD);
         end
      end else if (ph < BIN_W) begin
         ph <= ph + 1;
      end else if (ph == BIN_W) begin
         ph     <= ph + 1;
         m_done <= 1'b1;
`ifdef BCD2BIN_DIGIT_CHECK_EN
         m_bin   <= p_bad ? '0 : p_bin;
         m_err   <= p_bad;
         m_known <= 1'b1;
`else
         m_bin   <= p_bin;
         m_err   <= 1'b0;
         m_known <= !p_bad;
`endif
      end else begin
         ph <= 0; m_done <= 1'b0; m_busy <= 1'b0; m_err <= 1'b0;
      end
   end

   always @(negedge clk) begin
      check("busy", Busy, m_busy);
      check("done", Done, m_done);
      if (m_known) check("bin", Bin, m_bin);
`ifdef BCD2BIN_DIGIT_CHECK_EN
      if (m_done) check("err_at_done", Err, m_err);
`else
      check("err_tied", Err, 0);
`endif
   end

   task automatic wait_idle();
      for (int i = 0; i < 40 && Busy; i++) @(negedge clk);
      check("idle_timeout", Busy, 0);
   endtask

   task automatic wait_done(output int k_done);
      k_done = 0;
      for (int k = 1; k <= 40; k++) begin
         @(negedge clk);
         if (Done) begin
            k_done = k;
            break;
         end
      end
      if (k_done == 0) check("done_timeout", 0, 1);
   endtask

   task automatic convert(input logic [15:0] b, input int exp_bin, input logic exp_err,
                          input logic lit_bin, input string name);
      int busy_cyc = 0;
      int lat = 0;
      wait_idle();
      BCD = b; Start = 1'b1;
      @(posedge clk); #1 Start = 1'b0;
      for (int k = 1; k <= 40; k++) begin
         @(negedge clk);
         if (Busy) busy_cyc++;
         if (Done) begin
            lat = k - 1;
            break;
         end
      end
      check({name, "_latency"}, lat, BIN_W);
      check({name, "_busy_cycles"}, busy_cyc, BIN_W + 1);
      if (lit_bin) check({name, "_bin"}, Bin, exp_bin);
      check({name, "_err"}, Err, exp_err);
      @(negedge clk);
      check({name, "_done_single"}, Done, 0);
   endtask

   initial begin
      int k;
      longint last_done;
      int v;
      #2000000;
      $display("FAIL watchdog: simulation did not finish, n_cmp=%0d", n_cmp);
      $fatal(1, "watchdog");
   end

   initial begin
      int kd;
      longint last_edge;
      int v;

      repeat (3) @(negedge clk);
      check("rst_bin", Bin, 0);
      check("rst_busy", Busy, 0);
      check("rst_done", Done, 0);
      check("rst_err", Err, 0);
      rst_n = 1'b1;
      @(negedge clk);

      convert(16'h0000, 0, 1'b0, 1'b1, "zero");
      convert(16'h1023, 1023, 1'b0, 1'b1, "v1023");
      convert(16'h9999, 9999, 1'b0, 1'b1, "v9999");
      convert(16'h0010, 10, 1'b0, 1'b1, "v10");

      // Start during a conversion must be ignored.
      wait_idle();
      BCD = 16'h0500; Start = 1'b1;
      @(posedge clk); #1 Start = 1'b0;
      repeat (5) @(posedge clk);
      #1 BCD = 16'h0007; Start = 1'b1;
      @(posedge clk); #1 Start = 1'b0;
      wait_done(kd);
      check("ignored_start_bin", Bin, 500);
      convert(16'h0007, 7, 1'b0, 1'b1, "after_ignore");

      // Asynchronous reset mid-conversion.
      wait_idle();
      BCD = 16'h4321; Start = 1'b1;
      @(posedge clk); #1 Start = 1'b0;
      repeat (6) @(posedge clk);
      #3 rst_n = 1'b0;
      #1;
      check("abort_busy", Busy, 0);
      check("abort_done", Done, 0);
      check("abort_bin", Bin, 0);
      @(negedge clk); rst_n = 1'b1;
      repeat (20) begin
         @(negedge clk);
         check("abort_no_done", Done, 0);
      end
      convert(16'h4321, 4321, 1'b0, 1'b1, "after_abort");

`ifdef BCD2BIN_DIGIT_CHECK_EN
      convert(16'h00A5, 0, 1'b1, 1'b1, "bad_digit");
`else
      convert(16'h00A5, 0, 1'b0, 1'b0, "bad_digit");
`endif
      convert(16'h0042, 42, 1'b0, 1'b1, "v42");

      // Back-to-back conversions with Start held high and random valid values.
      wait_idle();
      last_edge = 0;
      BCD = to_bcd(9999); Start = 1'b1;
      for (int i = 0; i < 1500; i++) begin
         wait_done(kd);
         if (i > 0) check("b2b_spacing", 32'(edge_cnt - last_edge), BIN_W + 2);
         last_edge = edge_cnt;
         v = (i == 0) ? 0 : int'($urandom_range(0, 9999));
         BCD = to_bcd(v);
      end
      Start = 1'b0;
      wait_idle();
      repeat (3) @(negedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
